// File: rtl/fetch_pc_gen_if.sv
// Fetch-PC generator bundle: redirect/stall/halt controls in, I-cache fetch request out.
// fetch_pc_gen drives the request through the master modport; the consumer side uses slave.
interface fetch_pc_gen_if #(
   parameter int XLEN      = 64,
   parameter int NUM_REDIR = 2,
   parameter int SLOTS     = 4
);
   logic                      stall;
   logic [NUM_REDIR-1:0]      redir_valid;
   logic [NUM_REDIR*XLEN-1:0] redir_pc;
   logic                      halt;
   logic                      fetch_ready;
   logic                      fetch_valid;
   logic [XLEN-1:0]           cpc;
   logic [XLEN-1:0]           npc;
   logic [SLOTS-1:0]          fetch_mask;
   logic [NUM_REDIR-1:0]      redir_taken;
   logic                      pending;
   logic [1:0]                state;

   modport master (
      input  stall, redir_valid, redir_pc, halt, fetch_ready,
      output fetch_valid, cpc, npc, fetch_mask, redir_taken, pending, state
   );

   modport slave (
      output stall, redir_valid, redir_pc, halt, fetch_ready,
      input  fetch_valid, cpc, npc, fetch_mask, redir_taken, pending, state
   );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: one-cycle PC register with prioritised redirects, stall-time pending latch, BOOT/RUN/HALT.
// Request held stable while fetch_ready is low; only redirect, stall or halt withdraw it.
module fetch_pc_gen #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] BOOT_PC     = XLEN'(64'h8000_0000),
   parameter int              FETCH_BYTES = 16,
   parameter int              INST_BYTES  = 4,
   parameter int              NUM_REDIR   = 2
) (
   input logic            i_clk,
   input logic            i_rstn,
   fetch_pc_gen_if.master bus
);
   localparam int SLOTS = FETCH_BYTES / INST_BYTES;
   localparam int IOFF  = $clog2(INST_BYTES);
   localparam logic [XLEN-1:0] BLK_MASK  = XLEN'(FETCH_BYTES - 1);
   localparam logic [XLEN-1:0] INST_MASK = XLEN'(INST_BYTES - 1);
   localparam logic [XLEN-1:0] BLK_STEP  = XLEN'(FETCH_BYTES);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [XLEN-1:0]      pc_q, pc_d;
   logic [XLEN-1:0]      pend_pc_q, pend_pc_d;
   logic                 pend_q, pend_d;
   logic                 redir_any;
   logic [NUM_REDIR-1:0] redir_onehot;
   logic [XLEN-1:0]      redir_tgt;
   logic [XLEN-1:0]      seq_pc;
   logic [XLEN-1:0]      slot_idx;
   logic [SLOTS-1:0]     mask;
   logic                 fetch_valid;

   // Scan from the highest index down so the lowest asserted source is left standing.
   always_comb begin
      redir_any    = 1'b0;
      redir_onehot = '0;
      redir_tgt    = '0;
      for (int k = NUM_REDIR - 1; k >= 0; k--) begin
         if (bus.redir_valid[k]) begin
            redir_any       = 1'b1;
            redir_onehot    = '0;
            redir_onehot[k] = 1'b1;
            redir_tgt       = bus.redir_pc[k*XLEN +: XLEN] & ~INST_MASK;
         end
      end
   end

   assign seq_pc      = (pc_q & ~BLK_MASK) + BLK_STEP;
   assign slot_idx    = (pc_q & BLK_MASK) >> IOFF;
   assign fetch_valid = (state_q == ST_RUN) && !bus.stall;

   always_comb begin
      mask = '0;
      for (int i = 0; i < SLOTS; i++) begin
         mask[i] = (XLEN'(i) >= slot_idx);
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      if (bus.stall) begin
         if (redir_any) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_tgt;
         end
      end else if (redir_any) begin
         pc_d    = redir_tgt;
         pend_d  = 1'b0;
         state_d = ST_RUN;
      end else if (pend_q) begin
         pc_d    = pend_pc_q;
         pend_d  = 1'b0;
         state_d = ST_RUN;
      end else if (state_q == ST_RUN && bus.halt) begin
         state_d = ST_HALT;
      end else begin
         if (fetch_valid && bus.fetch_ready) begin
            pc_d = seq_pc;
         end
         // BOOT never issues a fetch; it only spends one unstalled cycle.
         if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         pc_q      <= BOOT_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign bus.fetch_valid = fetch_valid;
   assign bus.cpc         = pc_q;
   assign bus.npc         = pc_d;
   assign bus.fetch_mask  = mask;
   assign bus.redir_taken = redir_onehot;
   assign bus.pending     = pend_q;
   assign bus.state       = state_q;
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Parametrised fetch-PC generator at the head of the IFU; the next generation of the single-redirect PC generator.
- Generalised in XLEN, fetch-block size and number of redirect sources.
- Adds a valid/ready handshake to the I-cache, a per-slot fetch mask, and a pending-redirect latch, so redirects arriving during stall are not lost.
- Adds a BOOT/RUN/HALT state machine.

Parameters:
- XLEN, 64, PC width.
- BOOT_PC, 64'h8000_0000, reset fetch address.
- FETCH_BYTES, 16, fetch block size in bytes; power of two, at least INST_BYTES.
- INST_BYTES, 4, instruction slot size in bytes; power of two.
- NUM_REDIR, 2, number of redirect sources; index 0 has highest priority.
- Derived: SLOTS = FETCH_BYTES/INST_BYTES; OFF = log2(FETCH_BYTES); IOFF = log2(INST_BYTES).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  reset, asynchronous active-low.
- i_stall  in  1  freeze PC; pc_q must stay stable.
- i_redir_valid  in  NUM_REDIR  per-source redirect request.
- i_redir_pc  in  NUM_REDIR*XLEN  per-source target; source k occupies bits [k*XLEN +: XLEN].
- i_halt  in  1  request to stop fetching (WFI).
- i_fetch_ready  in  1  I-cache accepts the request.
- o_fetch_valid  out  1  fetch request valid.
- o_cpc  out  XLEN  current fetch address (pc_q).
- o_npc  out  XLEN  value pc_q takes at the next edge.
- o_fetch_mask  out  SLOTS  valid instruction slots in the current block.
- o_redir_taken  out  NUM_REDIR  one-hot; live redirect captured this cycle.
- o_pending  out  1  pending redirect held.
- o_state  out  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (asynchronous, i_rstn=0):
  - pc_q=BOOT_PC, state=BOOT, pending=0, pend_pc=0.
  - o_fetch_valid=0, o_redir_taken=0, o_fetch_mask=all ones when BOOT_PC is block-aligned.
- Live redirect: the lowest asserted index of i_redir_valid wins. The target has bits [IOFF-1:0] forced to 0. o_redir_taken is one-hot of the winner, combinational.
- Sequential next: seq = {pc_q[XLEN-1:OFF], OFF'b0} + FETCH_BYTES. Wraps modulo 2^XLEN.
- o_fetch_valid = (state==RUN) && !i_stall.
- o_fetch_mask[i] = (i >= pc_q[OFF-1:IOFF]).
- Next-PC priority, highest first:
  1. i_stall=1: pc_q holds. A live redirect is written to pend_pc and sets pending=1. A newer live redirect in a later cycle overwrites an older pending one.
  2. Live redirect: pc_q = target, pending cleared, state goes to RUN (from BOOT, RUN or HALT).
  3. pending=1: pc_q = pend_pc, pending cleared, state goes to RUN.
  4. state==RUN and i_halt=1: pc_q holds, state goes to HALT.
  5. o_fetch_valid and i_fetch_ready: pc_q = seq.
  6. Otherwise pc_q holds.
- A redirect in the same cycle as an accepted handshake still wins; the already-issued fetch is discarded downstream.
- BOOT lasts exactly one cycle after reset release unless stalled, then goes to RUN. A stall keeps the state in BOOT.
- HALT: fetch_valid=0; i_halt is ignored; exit only through priority 2 or 3.
- Backpressure: while valid && !ready, pc_q and mask are stable; a valid request is never withdrawn except by redirect, stall or halt.
- o_npc always equals the D input of pc_q.
- Reset mid-operation aborts everything within the same cycle; pending is lost.

Test Plan:
1. Reset release with i_fetch_ready=1:
   - Cycle 0: state=BOOT, valid=0, cpc=0x8000_0000.
   - Cycle 1: valid=1, mask=4'b1111.
   - Then cpc=0x8000_0010, then 0x8000_0020.
2. In RUN, redirect[1]=0x8000_0108, then i_fetch_ready=1:
   - Next cycle: cpc=0x8000_0108, mask=4'b1100, redir_taken=2'b10.
   - Following cycle: cpc=0x8000_0110, mask=4'b1111.
   - A target of 0x8000_0109 is forced to 0x8000_0108.
3. i_fetch_ready=0 for 3 cycles with cpc=0x8000_0040 -> valid=1 and cpc=0x8000_0040 throughout; ready=1 -> cpc=0x8000_0050.
4. i_stall=1 for 3 cycles, with redirect[1]=0x200 in stall cycle 1 and redirect[0]=0x300 in stall cycle 2:
   - pending=1, cpc unchanged during the stall.
   - The cycle after stall drops: cpc=0x300, pending=0.
5. redirect[0]=0x400 and redirect[1]=0x500 in the same cycle as i_halt=1 -> cpc=0x400, taken=2'b01, state stays RUN.
6. i_halt=1 in RUN:
   - Next cycle: state=HALT, valid=0, and the state is held with ready=1.
   - redirect[1]=0x600: next cycle state=RUN, cpc=0x600.
   - Pulsing i_rstn low mid-cycle: cpc=BOOT_PC and state=BOOT immediately.
